// File: rtl/attn_pkg.sv
// Shared definitions for the attention engine and its stream driver.
// Holds the driver FSM state type, the feature count per vector and the
// byte/score widths used on the engine's Q/K and result ports.
package attn_pkg;

    localparam int FEAT_PER_KEY = 4;
    localparam int Q_W          = 8;
    localparam int EX_W         = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_Q   = 3'd1,
        ST_SEND_K   = 3'd2,
        ST_HOLD_K   = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_WAIT_RES = 3'd5,
        ST_DONE     = 3'd6
    } drv_state_t;

    // Selects feature byte idx of a packed query vector (byte i = feature i).
    function automatic logic [Q_W-1:0] q_byte(input logic [FEAT_PER_KEY*Q_W-1:0] q,
                                              input logic [1:0]                 idx);
        return q[idx*Q_W +: Q_W];
    endfunction

endpackage

// File: rtl/attn_key_mem.sv
// Key vector register file: DEPTH x 8 bits, one synchronous write port and
// one asynchronous read port. Contents are not reset.
// Ports:
//   clk   - clock
//   we    - write strobe
//   waddr - write address (key*4+feature)
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational)
module attn_key_mem
    import attn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [Q_W-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [Q_W-1:0] rdata
);

    logic [Q_W-1:0] mem [DEPTH];

    // Write port; addresses beyond the populated depth are dropped.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/attn_stream_driver.sv
// Master-side driver of the attention engine's byte stream input. Streams a
// latched query vector interleaved with each key vector (q0,k0,...,q3,k3 per
// key), waits for the engine to settle, collects one exp() score per key and
// accumulates the softmax denominator.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   key_we/key_addr/key_data     - key memory write port (addr = key*4+feature)
//   start, q_vec                 - run request and query vector (latched on start)
//   busy                         - run in progress
//   tx_data/tx_vld/tx_rdy        - Q/K byte stream to the engine
//   rx_data/rx_vld/rx_rdy        - score stream from the engine
//   res_vld/res_idx/res_data     - per-key score report pulse
//   sum_out                      - running denominator
//   done                         - end-of-run pulse
// All outputs are registered.
module attn_stream_driver
    import attn_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int SETTLE   = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 key_we,
    input  logic [$clog2(NUM_KEYS*4)-1:0]        key_addr,
    input  logic [7:0]                           key_data,
    input  logic                                 start,
    input  logic [31:0]                          q_vec,
    output logic                                 busy,
    output logic [7:0]                           tx_data,
    output logic                                 tx_vld,
    input  logic                                 tx_rdy,
    input  logic [8:0]                           rx_data,
    input  logic                                 rx_vld,
    output logic                                 rx_rdy,
    output logic                                 res_vld,
    output logic [$clog2(NUM_KEYS)-1:0]          res_idx,
    output logic [8:0]                           res_data,
    output logic [9+$clog2(NUM_KEYS)-1:0]        sum_out,
    output logic                                 done
);

    localparam int KW = $clog2(NUM_KEYS);
    localparam int AW = $clog2(NUM_KEYS*FEAT_PER_KEY);
    localparam int SW = EX_W + KW;
    localparam int CW = $clog2(SETTLE+1);
    localparam logic [KW-1:0] LAST_KEY = KW'(NUM_KEYS-1);

    drv_state_t      state, state_next;
    logic [KW-1:0]   key, key_next;
    logic [1:0]      feat, feat_next;
    logic [CW-1:0]   settle_cnt, settle_cnt_next;
    logic [31:0]     q_lat, q_lat_next;
    logic [Q_W-1:0]  key_rd;

    logic            busy_next, tx_vld_next, rx_rdy_next, res_vld_next, done_next;
    logic [Q_W-1:0]  tx_data_next;
    logic [KW-1:0]   res_idx_next;
    logic [EX_W-1:0] res_data_next;
    logic [SW-1:0]   sum_next;

    // Address of the key byte is simply {key, feat} since there are 4 features.
    attn_key_mem #(
        .DEPTH (NUM_KEYS*FEAT_PER_KEY),
        .AW    (AW)
    ) u_key_mem (
        .clk   (clk),
        .we    (key_we),
        .waddr (key_addr),
        .wdata (key_data),
        .raddr ({key, feat}),
        .rdata (key_rd)
    );

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered, so the registered outputs line up with the state register.
    always_comb begin
        state_next      = state;
        key_next        = key;
        feat_next       = feat;
        settle_cnt_next = settle_cnt;
        q_lat_next      = q_lat;
        busy_next       = busy;
        tx_data_next    = 8'h00;
        tx_vld_next     = 1'b0;
        rx_rdy_next     = 1'b0;
        res_vld_next    = 1'b0;
        res_idx_next    = res_idx;
        res_data_next   = res_data;
        sum_next        = sum_out;
        done_next       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_SEND_Q;
                    q_lat_next   = q_vec;
                    sum_next     = '0;
                    key_next     = '0;
                    feat_next    = 2'd0;
                    busy_next    = 1'b1;
                    tx_data_next = q_byte(q_vec, 2'd0);
                    tx_vld_next  = 1'b1;
                end else begin
                    busy_next    = 1'b0;
                end
            end
            ST_SEND_Q: begin
                if (tx_vld && tx_rdy) begin
                    // Key byte is fetched here, so a write landing earlier is seen.
                    state_next   = ST_SEND_K;
                    tx_data_next = key_rd;
                    tx_vld_next  = 1'b1;
                end else begin
                    tx_data_next = tx_data;
                    tx_vld_next  = 1'b1;
                end
            end
            ST_SEND_K: begin
                // Single-cycle valid; the engine samples without a handshake.
                state_next   = ST_HOLD_K;
                tx_data_next = tx_data;
            end
            ST_HOLD_K: begin
                if (feat == 2'd3) begin
                    feat_next       = 2'd0;
                    settle_cnt_next = CW'(SETTLE-1);
                    state_next      = ST_SETTLE;
                end else begin
                    feat_next    = feat + 2'd1;
                    state_next   = ST_SEND_Q;
                    tx_data_next = q_byte(q_lat, feat + 2'd1);
                    tx_vld_next  = 1'b1;
                end
            end
            ST_SETTLE: begin
                // Scores arriving here are stale and are not acknowledged.
                if (settle_cnt == CW'(0)) begin
                    state_next  = ST_WAIT_RES;
                    rx_rdy_next = 1'b1;
                end else begin
                    settle_cnt_next = settle_cnt - CW'(1);
                end
            end
            ST_WAIT_RES: begin
                if (rx_vld && rx_rdy) begin
                    res_vld_next  = 1'b1;
                    res_idx_next  = key;
                    res_data_next = rx_data;
                    sum_next      = sum_out + SW'(rx_data);
                    if (key == LAST_KEY) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        key_next     = key + KW'(1);
                        state_next   = ST_SEND_Q;
                        tx_data_next = q_byte(q_lat, 2'd0);
                        tx_vld_next  = 1'b1;
                    end
                end else begin
                    rx_rdy_next = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            key        <= '0;
            feat       <= 2'd0;
            settle_cnt <= '0;
            q_lat      <= 32'h0;
            busy       <= 1'b0;
            tx_data    <= 8'h00;
            tx_vld     <= 1'b0;
            rx_rdy     <= 1'b0;
            res_vld    <= 1'b0;
            res_idx    <= '0;
            res_data   <= 9'h000;
            sum_out    <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            key        <= key_next;
            feat       <= feat_next;
            settle_cnt <= settle_cnt_next;
            q_lat      <= q_lat_next;
            busy       <= busy_next;
            tx_data    <= tx_data_next;
            tx_vld     <= tx_vld_next;
            rx_rdy     <= rx_rdy_next;
            res_vld    <= res_vld_next;
            res_idx    <= res_idx_next;
            res_data   <= res_data_next;
            sum_out    <= sum_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_attn_stream_driver.sv
// Bench for attn_stream_driver. A transaction-level model expands each run
// (query, keys, scores, engine wait choices) into an expected per-cycle
// output trace plus the stimulus for that cycle; one process replays it and
// compares the DUT every cycle.
module tb_attn_stream_driver;

    localparam int NK = 4;
    localparam int ST = 3;
    localparam int KW = 2;
    localparam int AW = 4;
    localparam int SW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_we;
    logic [AW-1:0] key_addr;
    logic [7:0]    key_data;
    logic          start;
    logic [31:0]   q_vec;
    logic          busy;
    logic [7:0]    tx_data;
    logic          tx_vld;
    logic          tx_rdy;
    logic [8:0]    rx_data;
    logic          rx_vld;
    logic          rx_rdy;
    logic          res_vld;
    logic [KW-1:0] res_idx;
    logic [8:0]    res_data;
    logic [SW-1:0] sum_out;
    logic          done;

    always #5 clk = ~clk;

    attn_stream_driver #(.NUM_KEYS(NK), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
        .start(start), .q_vec(q_vec), .busy(busy), .tx_data(tx_data), .tx_vld(tx_vld),
        .tx_rdy(tx_rdy), .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
        .res_vld(res_vld), .res_idx(res_idx), .res_data(res_data), .sum_out(sum_out),
        .done(done)
    );

    typedef struct {
        logic          e_busy, e_tvld, chk_td, e_rrdy, e_rvld, e_done;
        logic [7:0]    e_tdata;
        logic [KW-1:0] e_ridx;
        logic [8:0]    e_rdata;
        logic [SW-1:0] e_sum;
        logic          d_start, d_trdy, d_rxvld, d_we, tag;
        logic [31:0]   d_q;
        logic [8:0]    d_rxdata;
        logic [AW-1:0] d_addr;
        logic [7:0]    d_kdata;
    } rec_t;

    rec_t          tr[$];
    logic [7:0]    km [NK*4];
    logic [SW-1:0] m_sum;
    logic          m_busy;
    logic          pend;
    logic [KW-1:0] pend_idx;
    logic [8:0]    pend_data;
    int            n_chk;
    int            n_err;
    int            res_cnt;
    logic [KW-1:0] last_idx;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One expected cycle; a pending score report lands on the first cycle built after it.
    task automatic mk(output rec_t r, input logic tvld, input logic [7:0] td, input logic chk,
                      input logic rrdy, input logic trdy, input logic rxv, input logic [8:0] rxd);
        r.e_busy = m_busy;   r.e_tvld = tvld;    r.e_tdata = td;      r.chk_td = chk;
        r.e_rrdy = rrdy;     r.e_rvld = pend;    r.e_ridx = pend_idx; r.e_rdata = pend_data;
        r.e_sum = m_sum;     r.e_done = 1'b0;    pend = 1'b0;
        r.d_start = 1'b0;    r.d_q = $urandom;   r.d_trdy = trdy;     r.d_rxvld = rxv;
        r.d_rxdata = rxd;    r.d_we = 1'b0;      r.d_addr = '0;       r.d_kdata = 8'h00;
        r.tag = 1'b0;
    endtask

    task automatic build_load(input logic rnd, input logic [7:0] val);
        rec_t r;
        for (int a = 0; a < NK*4; a++) begin
            mk(r, 1'b0, 8'h00, 1'b0, 1'b0, rb(), rb(), 9'($urandom));
            r.d_we = 1'b1;
            r.d_addr = AW'(a);
            r.d_kdata = rnd ? 8'($urandom) : val;
            km[a] = r.d_kdata;
            tr.push_back(r);
        end
    endtask

    task automatic build_run(input logic [31:0] q, input logic [8:0] s0, input logic [8:0] s1,
                             input logic [8:0] s2, input logic [8:0] s3, input int fixed_wait,
                             input logic stale, input logic wr_mid, input logic rnd_wr,
                             input int tag_key);
        rec_t r;
        int nw;
        int nd;
        logic [8:0] sc [NK];
        sc[0] = s0; sc[1] = s1; sc[2] = s2; sc[3] = s3;
        m_busy = 1'b0;
        mk(r, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        r.d_start = 1'b1;
        r.d_q = q;
        tr.push_back(r);
        m_sum = '0;
        m_busy = 1'b1;
        for (int k = 0; k < NK; k++) begin
            for (int f = 0; f < 4; f++) begin
                nw = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
                for (int w = 0; w < nw; w++) begin
                    mk(r, 1'b1, q[f*8 +: 8], 1'b1, 1'b0, 1'b0, rb(), 9'($urandom));
                    if (rnd_wr && ($urandom_range(0, 3) == 0)) begin
                        r.d_we = 1'b1;
                        r.d_addr = AW'($urandom);
                        r.d_kdata = 8'($urandom);
                        km[r.d_addr] = r.d_kdata;
                    end
                    tr.push_back(r);
                end
                mk(r, 1'b1, q[f*8 +: 8], 1'b1, 1'b0, 1'b1, rb(), 9'($urandom));
                if (wr_mid && k == 0 && f == 0) begin
                    r.d_we = 1'b1;
                    r.d_addr = AW'(2);
                    r.d_kdata = ~km[2];
                    km[2] = r.d_kdata;
                    r.d_start = 1'b1;
                end
                tr.push_back(r);
                mk(r, 1'b1, km[k*4+f], 1'b1, 1'b0, rb(), rb(), 9'($urandom));
                tr.push_back(r);
                mk(r, 1'b0, km[k*4+f], 1'b1, 1'b0, rb(), rb(), 9'($urandom));
                r.tag = (k == tag_key && f == 1);
                tr.push_back(r);
            end
            for (int s = 0; s < ST; s++) begin
                mk(r, 1'b0, 8'h00, 1'b0, 1'b0, rb(), stale ? 1'b1 : rb(), stale ? 9'h111 : 9'($urandom));
                r.d_start = (s == 0);
                tr.push_back(r);
            end
            nd = $urandom_range(0, 3);
            for (int d = 0; d < nd; d++) begin
                mk(r, 1'b0, 8'h00, 1'b0, 1'b1, rb(), 1'b0, 9'($urandom));
                tr.push_back(r);
            end
            mk(r, 1'b0, 8'h00, 1'b0, 1'b1, rb(), 1'b1, sc[k]);
            tr.push_back(r);
            pend = 1'b1;
            pend_idx = KW'(k);
            pend_data = sc[k];
            m_sum = m_sum + SW'(sc[k]);
        end
        m_busy = 1'b0;
        mk(r, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        r.e_done = 1'b1;
        tr.push_back(r);
        mk(r, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        tr.push_back(r);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},    32'(busy),     32'h0);
        check({tag, "_tx_data"}, 32'(tx_data),  32'h0);
        check({tag, "_tx_vld"},  32'(tx_vld),   32'h0);
        check({tag, "_rx_rdy"},  32'(rx_rdy),   32'h0);
        check({tag, "_res_vld"}, 32'(res_vld),  32'h0);
        check({tag, "_res_idx"}, 32'(res_idx),  32'h0);
        check({tag, "_res_dat"}, 32'(res_data), 32'h0);
        check({tag, "_sum"},     32'(sum_out),  32'h0);
        check({tag, "_done"},    32'(done),     32'h0);
    endtask

    task automatic idle_inputs();
        start = 1'b0; tx_rdy = 1'b0; rx_vld = 1'b0; rx_data = 9'h000;
        key_we = 1'b0; key_addr = '0; key_data = 8'h00; q_vec = 32'h0;
    endtask

    // Replays the trace: compare on the falling edge, then drive for the next rising edge.
    task automatic exec(input logic abort);
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            check("busy",   32'(busy),    32'(tr[i].e_busy));
            check("tx_vld", 32'(tx_vld),  32'(tr[i].e_tvld));
            if (tr[i].chk_td) check("tx_data", 32'(tx_data), 32'(tr[i].e_tdata));
            check("rx_rdy",  32'(rx_rdy),  32'(tr[i].e_rrdy));
            check("res_vld", 32'(res_vld), 32'(tr[i].e_rvld));
            if (tr[i].e_rvld) begin
                check("res_idx",  32'(res_idx),  32'(tr[i].e_ridx));
                check("res_data", 32'(res_data), 32'(tr[i].e_rdata));
            end
            check("sum_out", 32'(sum_out), 32'(tr[i].e_sum));
            check("done",    32'(done),    32'(tr[i].e_done));
            if (res_vld) begin
                res_cnt++;
                last_idx = res_idx;
            end
            if (abort && tr[i].tag) begin
                idle_inputs();
                rst = 1'b1;
                #1;
                check_zero("midrst");
                @(negedge clk);
                rst = 1'b0;
                m_sum = '0;
                m_busy = 1'b0;
                pend = 1'b0;
                break;
            end
            start = tr[i].d_start;   q_vec = tr[i].d_q;          tx_rdy = tr[i].d_trdy;
            rx_vld = tr[i].d_rxvld;  rx_data = tr[i].d_rxdata;   key_we = tr[i].d_we;
            key_addr = tr[i].d_addr; key_data = tr[i].d_kdata;
        end
        tr.delete();
    endtask

    initial begin
        n_chk = 0; n_err = 0; res_cnt = 0; last_idx = '0;
        m_sum = '0; m_busy = 1'b0; pend = 1'b0; pend_idx = '0; pend_data = 9'h000;
        idle_inputs();
        rst = 1'b1;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Uniform 0x40 query and keys, score 0x05A per key.
        build_load(1'b0, 8'h40);
        exec(1'b0);
        build_run(32'h40404040, 9'h05A, 9'h05A, 9'h05A, 9'h05A, 0, 1'b0, 1'b0, 1'b0, -1);
        exec(1'b0);
        check("sum_uniform", 32'(sum_out), 32'h168);

        // Four distinct scores arriving in index order.
        build_load(1'b1, 8'h00);
        exec(1'b0);
        res_cnt = 0;
        build_run($urandom, 9'h040, 9'h080, 9'h0C0, 9'h1FF, -1, 1'b0, 1'b0, 1'b1, -1);
        exec(1'b0);
        check("sum_4scores", 32'(sum_out), 32'h37F);
        check("res_count",   32'(res_cnt), 32'd4);
        check("last_idx",    32'(last_idx), 32'd3);

        // Engine stalls 5 cycles on every query byte; stale 0x111 during settle.
        build_run($urandom, 9'h022, 9'h022, 9'h022, 9'h022, 5, 1'b1, 1'b0, 1'b1, -1);
        exec(1'b0);
        check("sum_stale", 32'(sum_out), 32'h088);

        // Write to the active key and a start pulse while busy.
        build_run($urandom, 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom),
                  -1, 1'b0, 1'b1, 1'b0, -1);
        exec(1'b0);

        // Reset in the middle of a key hold, then a full replay.
        build_run($urandom, 9'h1AB, 9'h0CD, 9'h011, 9'h100, -1, 1'b0, 1'b0, 1'b0, 1);
        exec(1'b1);
        build_run($urandom, 9'h1AB, 9'h0CD, 9'h011, 9'h100, -1, 1'b0, 1'b0, 1'b0, -1);
        exec(1'b0);
        check("sum_replay", 32'(sum_out), 32'h389);

        for (int n = 0; n < 6; n++) begin
            build_run($urandom, 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom),
                      -1, rb(), rb(), 1'b1, -1);
            exec(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
